// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch front end: repeat-FSM encoding, input indices and
// default debounce/repeat timing in 100 Hz ticks.
package stopwatch_pkg;

    localparam logic [1:0] RPT_IDLE   = 2'b00;
    localparam logic [1:0] RPT_DELAY  = 2'b01;
    localparam logic [1:0] RPT_REPEAT = 2'b10;

    typedef enum logic [1:0] {
        RptIdle   = RPT_IDLE,
        RptDelay  = RPT_DELAY,
        RptRepeat = RPT_REPEAT
    } rpt_state_e;

    localparam int unsigned DEF_DEBOUNCE_TICKS = 3;
    localparam int unsigned DEF_REPEAT_DELAY   = 50;
    localparam int unsigned DEF_REPEAT_RATE    = 10;

    localparam int unsigned NUM_INPUTS = 5;
    localparam int unsigned IDX_START  = 0;
    localparam int unsigned IDX_STOP   = 1;
    localparam int unsigned IDX_MIN    = 2;
    localparam int unsigned IDX_HOUR   = 3;
    localparam int unsigned IDX_MODE   = 4;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw input; rise is a registered
// one-cycle pulse on a debounced 0->1 change.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic clk_100Hz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;

    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_level <= ~r_level;
                r_rise  <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/btn_conditioner.sv
// Stopwatch input conditioner: debounces five inputs, arbitrates start/stop and, when
// BTN_AUTOREPEAT_EN is defined, auto-repeats the minute/hour adjust pulses while held.
module btn_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic clk_100Hz,
    input  logic rst,
    input  logic btn_start_raw,
    input  logic btn_stop_raw,
    input  logic btn_min_raw,
    input  logic btn_hour_raw,
    input  logic sw_mode_raw,
    output logic start,
    output logic stop,
    output logic min_inc,
    output logic hour_inc,
    output logic countdown_mode
);

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_level;
    logic [NUM_INPUTS-1:0] w_rise;
    logic [1:0]            w_adj;
    logic                  w_unused;

    assign w_raw = {sw_mode_raw, btn_hour_raw, btn_min_raw, btn_stop_raw, btn_start_raw};

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .clk_100Hz(clk_100Hz),
            .rst      (rst),
            .raw      (w_raw[gi]),
            .level    (w_level[gi]),
            .rise     (w_rise[gi])
        );
    end

    // Stop wins a same-cycle collision; the start press is simply lost.
    assign stop           = w_rise[IDX_STOP];
    assign start          = w_rise[IDX_START] & ~w_rise[IDX_STOP];
    assign countdown_mode = w_level[IDX_MODE];

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW = cnt_width(RPT_MAX - 1);
    localparam logic [RW-1:0] DLY_TERM  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_TERM = RW'(REPEAT_RATE - 1);

    for (genvar ga = 0; ga < 2; ga++) begin : g_rpt
        localparam int unsigned IDX = IDX_MIN + ga;

        rpt_state_e    r_state;
        logic [RW-1:0] r_rcnt;
        logic          w_pulse;

        always_ff @(posedge clk_100Hz or posedge rst) begin
            if (rst) begin
                r_state <= RptIdle;
                r_rcnt  <= '0;
            end else if (!w_level[IDX]) begin
                r_state <= RptIdle;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    RptIdle: begin
                        if (w_rise[IDX]) begin
                            r_state <= RptDelay;
                            r_rcnt  <= '0;
                        end
                    end
                    RptDelay: begin
                        if (r_rcnt == DLY_TERM) begin
                            r_state <= RptRepeat;
                            r_rcnt  <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    RptRepeat: begin
                        if (r_rcnt == RATE_TERM) r_rcnt <= '0;
                        else                     r_rcnt <= r_rcnt + 1'b1;
                    end
                    default: begin
                        r_state <= RptIdle;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end

        // Decoded purely from flops; a debounced release masks any pulse due that cycle.
        always_comb begin
            w_pulse = 1'b0;
            if (w_level[IDX]) begin
                case (r_state)
                    RptIdle:   w_pulse = w_rise[IDX];
                    RptDelay:  w_pulse = (r_rcnt == DLY_TERM);
                    RptRepeat: w_pulse = (r_rcnt == RATE_TERM);
                    default:   w_pulse = 1'b0;
                endcase
            end
        end

        assign w_adj[ga] = w_pulse;
    end

    assign w_unused = ^{w_level[IDX_START], w_level[IDX_STOP], w_rise[IDX_MODE]};
`else
    assign w_adj    = w_rise[IDX_HOUR:IDX_MIN];
    assign w_unused = ^{w_level[IDX_HOUR:IDX_START], w_rise[IDX_MODE],
                        32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    assign min_inc  = w_adj[0];
    assign hour_inc = w_adj[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed, table-driven bench for btn_conditioner at default timing (3/50/10 ticks).
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk_100Hz = 1'b0;
    logic rst = 1'b1;
    logic btn_start_raw = 1'b0, btn_stop_raw = 1'b0, btn_min_raw = 1'b0;
    logic btn_hour_raw = 1'b0, sw_mode_raw = 1'b0;
    logic start, stop, min_inc, hour_inc, countdown_mode;

    btn_conditioner u_dut (
        .clk_100Hz     (clk_100Hz),
        .rst           (rst),
        .btn_start_raw (btn_start_raw),
        .btn_stop_raw  (btn_stop_raw),
        .btn_min_raw   (btn_min_raw),
        .btn_hour_raw  (btn_hour_raw),
        .sw_mode_raw   (sw_mode_raw),
        .start         (start),
        .stop          (stop),
        .min_inc       (min_inc),
        .hour_inc      (hour_inc),
        .countdown_mode(countdown_mode)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    // Bit order for both fields: {mode, hour, min, stop, start}.
    typedef struct packed {
        logic [4:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic [4:0] in, input logic [4:0] exp, input int reps);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        for (int r = 0; r < reps; r++) vecs.push_back(v);
    endfunction

    // Adjust pulses k edges after the press is first sampled (k=0 is E1).
    function automatic bit adj_exp(input int k);
        return (k == 4) || (AR && k >= 54 && ((k - 54) % 10) == 0);
    endfunction

    function automatic logic [4:0] outs();
        return {countdown_mode, hour_inc, min_inc, stop, start};
    endfunction

    task automatic drive(input logic [4:0] in);
        {sw_mode_raw, btn_hour_raw, btn_min_raw, btn_stop_raw, btn_start_raw} = in;
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] got,
                         input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100Hz);
        #1;
    endtask

    initial begin
        drive(5'b00000);
        rst = 1'b1;
        repeat (3) @(posedge clk_100Hz);
        #1;
        check("reset", 0, outs(), 5'b00000);
        rst = 1'b0;
        tick();
        check("post_reset", 0, outs(), 5'b00000);

        // Start press: one pulse at E5, none on release.
        add(5'b00001, 5'b00000, 4);
        add(5'b00001, 5'b00001, 1);
        add(5'b00001, 5'b00000, 3);
        add(5'b00000, 5'b00000, 8);
        // Stop bounce (2 high, 1 low, 2 high) is rejected, then a clean 10-cycle hold.
        add(5'b00010, 5'b00000, 2);
        add(5'b00000, 5'b00000, 1);
        add(5'b00010, 5'b00000, 2);
        add(5'b00000, 5'b00000, 6);
        add(5'b00010, 5'b00000, 4);
        add(5'b00010, 5'b00010, 1);
        add(5'b00010, 5'b00000, 5);
        add(5'b00000, 5'b00000, 8);
        // Simultaneous start and stop: stop only.
        add(5'b00011, 5'b00000, 4);
        add(5'b00011, 5'b00010, 1);
        add(5'b00011, 5'b00000, 2);
        add(5'b00000, 5'b00000, 8);
        // Mode switch on, 2-cycle dip ignored, then off.
        add(5'b10000, 5'b00000, 4);
        add(5'b10000, 5'b10000, 6);
        add(5'b00000, 5'b10000, 2);
        add(5'b10000, 5'b10000, 8);
        add(5'b00000, 5'b10000, 4);
        add(5'b00000, 5'b00000, 4);
        // Minute held 100 cycles; nothing after the debounced release.
        for (int k = 0; k < 100; k++) add(5'b00100, {2'b00, adj_exp(k), 2'b00}, 1);
        add(5'b00000, 5'b00000, 10);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            tick();
            check("vec", i, outs(), vecs[i].exp);
        end

        // Hour and mode held, reset asserted during a cycle where hour may pulse.
        drive(5'b11000);
        for (int k = 0; k < 75; k++) begin
            tick();
            check("pre_rst", k, outs(), {k >= 4, adj_exp(k), 3'b000});
        end
        rst = 1'b1;
        #2;
        check("rst_async", 0, outs(), 5'b00000);
        tick();
        check("rst_hold", 0, outs(), 5'b00000);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("post_rst", k, outs(), {k >= 4, adj_exp(k), 3'b000});
        end
        drive(5'b00000);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
